// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous RAM between the instruction-fetch (IF)
// and data-memory (DM) stages of the pipeline. Data accesses win by default.
// A starvation counter lets fetch win a tie once it has waited long enough.
//
// Ports:
//   CLK, CLR                      clock (rising edge), async active-low reset
//   if_req/if_addr                fetch request, held until if_ready
//   if_rdata/if_ready             fetch data and one-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata data request, held until dm_ready
//   dm_rdata/dm_ready             load data and one-cycle completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata  RAM strobe and request fields
//   mem_rdata                     RAM read data, valid MEM_LAT cycles after mem_en
//   conflict_cnt                  saturating count of cycles where both requests
//                                 wait with no grant and no completion
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       conflict_cnt
);

    localparam int unsigned LAT_W    = $clog2(MEM_LAT + 1);
    localparam int unsigned STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {StIdle, StBusyIf, StBusyDm} state_e;

    state_e              state_q, state_d;
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic [15:0]         conflict_cnt_q, conflict_cnt_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;

    logic lat_done;
    logic if_elig, dm_elig;
    logic if_cand, dm_cand;
    logic if_grant, dm_grant;

    always_comb begin
        lat_done = (state_q != StIdle) && (lat_cnt_q == LAT_W'(1));
        if_ready = (state_q == StBusyIf) && lat_done;
        dm_ready = (state_q == StBusyDm) && lat_done;

        // A requester completing this cycle cannot be granted again until
        // the next cycle, which gives back-to-back same-port accesses one IDLE gap.
        if_elig = if_req && !if_ready;
        dm_elig = dm_req && !dm_ready;

        // Chained grants go only to the port that is not finishing.
        if_cand = if_elig && ((state_q == StIdle) || ((state_q == StBusyDm) && lat_done));
        dm_cand = dm_elig && ((state_q == StIdle) || ((state_q == StBusyIf) && lat_done));

        if_grant = if_cand && (!dm_cand || (starve_cnt_q >= STARVE_W'(STARVE_MAX)));
        dm_grant = dm_cand && !if_grant;

        // Memory strobe is combinational off the grant; CLR forces it quiet so
        // the RAM sees nothing while the arbiter is held in reset.
        mem_en    = (if_grant || dm_grant) && CLR;
        mem_we    = dm_grant && dm_we && CLR;
        mem_addr  = '0;
        mem_wdata = '0;
        if (CLR) begin
            if (dm_grant) begin
                mem_addr  = dm_addr;
                mem_wdata = dm_wdata;
            end else if (if_grant) begin
                mem_addr = if_addr;
            end
        end

        if_rdata_d = if_ready ? mem_rdata : if_rdata_q;
        dm_rdata_d = dm_ready ? mem_rdata : dm_rdata_q;
        if_rdata   = if_rdata_d;
        dm_rdata   = dm_rdata_d;

        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        if (state_q != StIdle) begin
            if (lat_done) begin
                state_d   = StIdle;
                lat_cnt_d = '0;
            end else begin
                lat_cnt_d = lat_cnt_q - LAT_W'(1);
            end
        end
        if (if_grant) begin
            state_d   = StBusyIf;
            lat_cnt_d = LAT_W'(MEM_LAT);
        end else if (dm_grant) begin
            state_d   = StBusyDm;
            lat_cnt_d = LAT_W'(MEM_LAT);
        end

        starve_cnt_d = starve_cnt_q;
        if (if_grant) begin
            starve_cnt_d = '0;
        end else if (if_req && !if_ready && (starve_cnt_q < STARVE_W'(STARVE_MAX))) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
        end

        conflict_cnt_d = conflict_cnt_q;
        if (if_req && dm_req && !if_grant && !dm_grant && !if_ready && !dm_ready &&
            (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end

        conflict_cnt = conflict_cnt_q;
    end

    // Reset abandons any outstanding access: returning to IDLE suppresses the
    // ready pulse, so a late mem_rdata is never forwarded.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q        <= StIdle;
            lat_cnt_q      <= '0;
            starve_cnt_q   <= '0;
            conflict_cnt_q <= '0;
            if_rdata_q     <= '0;
            dm_rdata_q     <= '0;
        end else begin
            state_q        <= state_d;
            lat_cnt_q      <= lat_cnt_d;
            starve_cnt_q   <= starve_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
            if_rdata_q     <= if_rdata_d;
            dm_rdata_q     <= dm_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. The main instance runs with
// MEM_LAT=3 and STARVE_MAX=2 against a small RAM model; a second instance with
// a long latency is held in permanent contention to saturate conflict_cnt.
module tb_mem_port_arbiter;

    localparam int unsigned MEM_LAT  = 3;
    localparam int unsigned SAT_LAT  = 1000;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        bit          chk_data;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata;
    logic        if_ready, dm_ready;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] conflict_cnt;

    logic        clr_sat, sat_if_req, sat_dm_req;
    logic [31:0] sat_if_rdata, sat_dm_rdata, sat_mem_addr, sat_mem_wdata;
    logic        sat_if_ready, sat_dm_ready, sat_mem_en, sat_mem_we;
    logic [15:0] sat_conflict_cnt;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    exp_t if_q[$];
    exp_t dm_q[$];
    exp_t mon_if, mon_dm;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MEM_LAT   (MEM_LAT),
        .STARVE_MAX(2)
    ) u_dut (
        .CLK         (clk),
        .CLR         (clr),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_ready    (if_ready),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_rdata    (dm_rdata),
        .dm_ready    (dm_ready),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .conflict_cnt(conflict_cnt)
    );

    mem_port_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MEM_LAT   (SAT_LAT),
        .STARVE_MAX(4)
    ) u_sat (
        .CLK         (clk),
        .CLR         (clr_sat),
        .if_req      (sat_if_req),
        .if_addr     (32'h0),
        .if_rdata    (sat_if_rdata),
        .if_ready    (sat_if_ready),
        .dm_req      (sat_dm_req),
        .dm_we       (1'b0),
        .dm_addr     (32'h40),
        .dm_wdata    (32'h0),
        .dm_rdata    (sat_dm_rdata),
        .dm_ready    (sat_dm_ready),
        .mem_en      (sat_mem_en),
        .mem_we      (sat_mem_we),
        .mem_addr    (sat_mem_addr),
        .mem_wdata   (sat_mem_wdata),
        .mem_rdata   (32'h0),
        .conflict_cnt(sat_conflict_cnt)
    );

    // RAM model: contents loaded on the first clock, reads delivered MEM_LAT
    // cycles after the strobe.
    function automatic logic [31:0] rom(input int a);
        case (a)
            32'h00:  rom = 32'h2008_0005;
            32'h04:  rom = 32'h3333_4444;
            32'h08:  rom = 32'h5555_6666;
            32'h80:  rom = 32'h1111_2222;
            default: rom = 32'h0;
        endcase
    endfunction

    logic [31:0] ram [256];
    logic [31:0] rd_pipe [MEM_LAT];
    bit          mem_init;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= rom(i * 4);
            mem_init <= 1'b1;
        end else if (mem_en && mem_we) begin
            ram[mem_addr[9:2]] <= mem_wdata;
        end
        rd_pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr[9:2]] : 32'h0;
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_if(input logic [31:0] d, input int c, input bit cd);
        exp_t e;
        e.data = d; e.cyc = c; e.chk_data = cd;
        if_q.push_back(e);
    endfunction

    function automatic void push_dm(input logic [31:0] d, input int c, input bit cd);
        exp_t e;
        e.data = d; e.cyc = c; e.chk_data = cd;
        dm_q.push_back(e);
    endfunction

    // Monitor: every ready pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (if_ready) begin
            if (if_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL if_ready_spurious: got 1, expected 0 (cycle %0d)", cyc);
            end else begin
                mon_if = if_q.pop_front();
                chk("if_ready_cycle", cyc, mon_if.cyc);
                if (mon_if.chk_data) chk("if_rdata", if_rdata, mon_if.data);
            end
        end
        if (dm_ready) begin
            if (dm_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL dm_ready_spurious: got 1, expected 0 (cycle %0d)", cyc);
            end else begin
                mon_dm = dm_q.pop_front();
                chk("dm_ready_cycle", cyc, mon_dm.cyc);
                if (mon_dm.chk_data) chk("dm_rdata", dm_rdata, mon_dm.data);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic main_seq();
        int t0;
        tick(3);
        @(negedge clk);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_dm_ready", dm_ready, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_conflict", conflict_cnt, 0);
        tick(1);
        clr = 1'b1;

        // Tie in IDLE with starve_cnt=0: DM first, IF chained at DM completion.
        tick(1);
        t0 = cyc;
        if_req = 1'b1; if_addr = 32'h04;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
        push_dm(32'h1111_2222, t0 + 3, 1'b1);
        push_if(32'h3333_4444, t0 + 6, 1'b1);
        @(negedge clk);
        chk("tie_dm_addr", mem_addr, 32'h80);
        chk("tie_mem_en", mem_en, 1);
        tick(3);
        @(negedge clk);
        chk("chain_if_addr", mem_addr, 32'h04);
        chk("chain_mem_en", mem_en, 1);
        tick(1); dm_req = 1'b0;
        tick(3); if_req = 1'b0;
        @(negedge clk);
        chk("conflict_after_tie", conflict_cnt, 2);

        // starve_cnt is now 2 (= STARVE_MAX) from the waits above: IF wins the tie.
        tick(1);
        t0 = cyc;
        if_req = 1'b1; if_addr = 32'h08;
        dm_req = 1'b1; dm_addr = 32'h80;
        push_if(32'h5555_6666, t0 + 3, 1'b1);
        push_dm(32'h1111_2222, t0 + 6, 1'b1);
        @(negedge clk);
        chk("starved_if_wins", mem_addr, 32'h08);
        tick(3);
        @(negedge clk);
        chk("chain_dm_addr", mem_addr, 32'h80);
        tick(1); if_req = 1'b0;
        tick(3); dm_req = 1'b0;
        @(negedge clk);
        chk("conflict_after_starve", conflict_cnt, 4);

        // Lone fetch, then back-to-back fetch with one IDLE gap.
        tick(1);
        t0 = cyc;
        if_req = 1'b1; if_addr = 32'h00;
        push_if(32'h2008_0005, t0 + 3, 1'b1);
        @(negedge clk);
        chk("fetch_mem_en", mem_en, 1);
        chk("fetch_mem_addr", mem_addr, 32'h00);
        chk("fetch_mem_we", mem_we, 0);
        tick(1);
        @(negedge clk);
        chk("busy_no_grant", mem_en, 0);
        tick(2);
        @(negedge clk);
        chk("ready_cycle_no_regrant", mem_en, 0);
        tick(1);
        if_addr = 32'h04;
        push_if(32'h3333_4444, t0 + 7, 1'b1);
        @(negedge clk);
        chk("b2b_grant", mem_en, 1);
        chk("b2b_addr", mem_addr, 32'h04);
        tick(4); if_req = 1'b0;

        // Store then load of the same word.
        tick(1);
        t0 = cyc;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h84; dm_wdata = 32'hDEAD_BEEF;
        push_dm(32'h0, t0 + 3, 1'b0);
        @(negedge clk);
        chk("store_mem_we", mem_we, 1);
        chk("store_mem_addr", mem_addr, 32'h84);
        chk("store_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick(1);
        @(negedge clk);
        chk("store_we_one_cycle", mem_we, 0);
        tick(3);
        dm_we = 1'b0; dm_wdata = 32'h0;
        push_dm(32'hDEAD_BEEF, t0 + 7, 1'b1);
        @(negedge clk);
        chk("load_mem_we", mem_we, 0);
        chk("load_mem_en", mem_en, 1);
        tick(4); dm_req = 1'b0;
        @(negedge clk);
        chk("dm_rdata_hold", dm_rdata, 32'hDEAD_BEEF);
        chk("if_rdata_hold", if_rdata, 32'h3333_4444);

        // Reset while the fetch has lat_cnt=2; its ready must never appear.
        tick(1);
        t0 = cyc;
        if_req = 1'b1; if_addr = 32'h00;
        tick(2);
        clr = 1'b0;
        @(negedge clk);
        chk("midrst_if_ready", if_ready, 0);
        chk("midrst_mem_en", mem_en, 0);
        chk("midrst_mem_addr", mem_addr, 0);
        chk("midrst_if_rdata", if_rdata, 0);
        chk("midrst_dm_rdata", dm_rdata, 0);
        chk("midrst_conflict", conflict_cnt, 0);
        tick(1);
        if_req = 1'b0;
        @(negedge clk);
        chk("midrst_no_late_ready", if_ready, 0);
        tick(1);
        clr = 1'b1;
        tick(1);
        if_req = 1'b1; if_addr = 32'h08;
        push_if(32'h5555_6666, t0 + 8, 1'b1);
        @(negedge clk);
        chk("post_rst_grant", mem_en, 1);
        tick(4); if_req = 1'b0;
        tick(2);
    endtask

    // Permanent contention on a long-latency instance: 999 counted cycles per
    // transaction, so the counter passes 0xFFFF during the 66th transaction.
    task automatic sat_seq();
        tick(2);
        clr_sat = 1'b1;
        tick(1);
        sat_if_req = 1'b1;
        sat_dm_req = 1'b1;
        tick(1000);
        @(negedge clk);
        chk("sat_first_window", sat_conflict_cnt, 999);
        tick(65000);
        @(negedge clk);
        chk("sat_reached_max", sat_conflict_cnt, 32'hFFFF);
        tick(500);
        @(negedge clk);
        chk("sat_no_wrap", sat_conflict_cnt, 32'hFFFF);
    endtask

    initial begin
        clr = 1'b0; clr_sat = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
        sat_if_req = 1'b0; sat_dm_req = 1'b0;
        fork
            main_seq();
            sat_seq();
        join
        chk("if_queue_drained", if_q.size(), 0);
        chk("dm_queue_drained", dm_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
